// File: rtl/cdc_pkg.sv
// ----------------------------------------------------------------------------
// cdc_pkg
// Shared constants and helpers for the clk_a -> clk_b quasi-static crossing.
//   CDC_DEFAULT_WIDTH  : default width of the crossing value
//   CDC_DEFAULT_STAGES : default destination synchronizer depth
//   CDC_MIN/MAX_STAGES : legal synchronizer depth range
//   CDC_RST_STAGES     : depth of the destination reset synchronizer
//   cdc_stages_ok()    : elaboration-time range check for STAGES
// ----------------------------------------------------------------------------
package cdc_pkg;

    localparam int CDC_DEFAULT_WIDTH  = 4;
    localparam int CDC_DEFAULT_STAGES = 2;
    localparam int CDC_MIN_STAGES     = 2;
    localparam int CDC_MAX_STAGES     = 4;
    localparam int CDC_RST_STAGES     = 2;

    function automatic bit cdc_stages_ok(input int stages);
        return (stages >= CDC_MIN_STAGES) && (stages <= CDC_MAX_STAGES);
    endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// ----------------------------------------------------------------------------
// cdc_sync_chain
// Plain flop chain with asynchronous active-high reset to 0. Stage 0 samples
// i_d, stage k samples stage k-1 on every rising i_clk.
//   i_clk : destination clock
//   i_rst : asynchronous reset, active high
//   i_d   : WIDTH-bit input from the other domain (or a constant 1 when
//           used as a reset synchronizer)
//   o_q   : all stages, o_q[0] = first flop, o_q[STAGES-1] = last flop
// ----------------------------------------------------------------------------
module cdc_sync_chain
    import cdc_pkg::*;
#(
    parameter int WIDTH  = CDC_DEFAULT_WIDTH,
    parameter int STAGES = CDC_DEFAULT_STAGES
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [WIDTH-1:0]             i_d,
    output logic [STAGES-1:0][WIDTH-1:0] o_q
);

    // Shift up by one stage: the input lands in stage 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_q <= '0;
        else       o_q <= {o_q[STAGES-2:0], i_d};
    end

endmodule

// File: rtl/double_flop_sync.sv
// ----------------------------------------------------------------------------
// double_flop_sync
// Synchronizes a slowly varying multi-bit status value from clk_a to clk_b.
// The value is launched from src_q (clk_a) straight into a STAGES-deep flop
// chain in clk_b. Bits cross independently: the source must hold the value
// for at least STAGES+1 clk_b periods (or be gray coded).
//   clk_a         : source clock, launch register src_q
//   rst           : asynchronous active-high reset for both domains
//   clk_b         : destination clock, asynchronous to clk_a
//   rand_signal_a : WIDTH-bit value in clk_a
//   rand_signal_b : synchronized value (last chain stage)
//   change_b      : one-cycle pulse, one clk_b after rand_signal_b changes
//   stable_b      : registered equality of the last two chain stages
// ----------------------------------------------------------------------------
module double_flop_sync
    import cdc_pkg::*;
#(
    parameter int WIDTH  = CDC_DEFAULT_WIDTH,
    parameter int STAGES = CDC_DEFAULT_STAGES
) (
    input  logic             clk_a,
    input  logic             rst,
    input  logic             clk_b,
    input  logic [WIDTH-1:0] rand_signal_a,
    output logic [WIDTH-1:0] rand_signal_b,
    output logic             change_b,
    output logic             stable_b
);

    if (!cdc_stages_ok(STAGES)) begin : g_bad_stages
        $error("double_flop_sync: STAGES must be in 2..4");
    end

    // ---------------- source launch (clk_a) ----------------
    logic [WIDTH-1:0] src_q;

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) src_q <= '0;
        else     src_q <= rand_signal_a;
    end

    // ---------------- destination reset (clk_b) ----------------
    // A constant 1 walks through the chain after rst falls; rst_b_int is
    // released only once every stage holds 1, i.e. on the 2nd clk_b edge.
    // Assertion is immediate because the chain itself resets on rst.
    logic [CDC_RST_STAGES-1:0][0:0] w_rst_stg;
    logic                           rst_b_int;

    cdc_sync_chain #(
        .WIDTH  (1),
        .STAGES (CDC_RST_STAGES)
    ) u_rst_sync (
        .i_clk (clk_b),
        .i_rst (rst),
        .i_d   (1'b1),
        .o_q   (w_rst_stg)
    );

    assign rst_b_int = ~(&w_rst_stg);

    // ---------------- data synchronizer (clk_b) ----------------
    // src_q feeds the first flop directly, no logic in between.
    logic [STAGES-1:0][WIDTH-1:0] w_data_stg;
    logic [WIDTH-1:0]             sync_ff1;
    logic [WIDTH-1:0]             sync_ff2;

    cdc_sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_data_sync (
        .i_clk (clk_b),
        .i_rst (rst_b_int),
        .i_d   (src_q),
        .o_q   (w_data_stg)
    );

    // Stage taps kept under fixed names for hierarchical probing.
    assign sync_ff1      = w_data_stg[0];
    assign sync_ff2      = w_data_stg[1];
    assign rand_signal_b = w_data_stg[STAGES-1];

    // ---------------- change / stability flags ----------------
    // prev_b resets with the chain, so reset itself never looks like a change.
    logic [WIDTH-1:0] prev_b;

    always_ff @(posedge clk_b or posedge rst_b_int) begin
        if (rst_b_int) begin
            prev_b   <= '0;
            change_b <= 1'b0;
            stable_b <= 1'b0;
        end else begin
            prev_b   <= rand_signal_b;
            change_b <= (rand_signal_b != prev_b);
            stable_b <= (w_data_stg[STAGES-1] == w_data_stg[STAGES-2]);
        end
    end

endmodule

// File: tb/tb_double_flop_sync.sv
// ----------------------------------------------------------------------------
// tb_double_flop_sync
// Directed bench for double_flop_sync. Two instances share stimulus: the
// default STAGES=2 and a STAGES=3 copy used to compare latency.
// ----------------------------------------------------------------------------
module tb_double_flop_sync;

    localparam int W = 4;

    logic         clk_a = 1'b0;
    logic         clk_b = 1'b0;
    logic         rst   = 1'b1;
    logic [W-1:0] rand_signal_a = '0;

    logic [W-1:0] rand_b2, rand_b3;
    logic         change_b2, change_b3;
    logic         stable_b2, stable_b3;

    int errors = 0;
    int checks = 0;

    // latencies (clk_b edges) recorded for the depth comparison
    int lat_basic2 = 0, lat_basic3 = 0;
    int lat_rst2   = 0, lat_rst3   = 0;

    always #5 clk_a = ~clk_a;
    always #7 clk_b = ~clk_b;

    double_flop_sync #(.WIDTH(W), .STAGES(2)) dut (
        .clk_a         (clk_a),
        .rst           (rst),
        .clk_b         (clk_b),
        .rand_signal_a (rand_signal_a),
        .rand_signal_b (rand_b2),
        .change_b      (change_b2),
        .stable_b      (stable_b2)
    );

    double_flop_sync #(.WIDTH(W), .STAGES(3)) dut3 (
        .clk_a         (clk_a),
        .rst           (rst),
        .clk_b         (clk_b),
        .rand_signal_a (rand_signal_a),
        .rand_signal_b (rand_b3),
        .change_b      (change_b3),
        .stable_b      (stable_b3)
    );

    // ------------------------------------------------------------------
    task automatic test_reset();
        rand_signal_a = '0;
        rst = 1'b1;
        #29;
        checks++; if (rand_b2 !== 4'd0)       begin errors++; $display("FAIL reset_rand_b got=%h exp=0", rand_b2); end
        checks++; if (dut.sync_ff1 !== 4'd0)  begin errors++; $display("FAIL reset_sync_ff1 got=%h exp=0", dut.sync_ff1); end
        checks++; if (dut.sync_ff2 !== 4'd0)  begin errors++; $display("FAIL reset_sync_ff2 got=%h exp=0", dut.sync_ff2); end
        checks++; if (change_b2 !== 1'b0)     begin errors++; $display("FAIL reset_change_b got=%b exp=0", change_b2); end
        checks++; if (stable_b2 !== 1'b0)     begin errors++; $display("FAIL reset_stable_b got=%b exp=0", stable_b2); end
        checks++; if (rand_b3 !== 4'd0)       begin errors++; $display("FAIL reset_rand_b3 got=%h exp=0", rand_b3); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic();
        logic [W-1:0] r2 [1:8];
        logic [W-1:0] r3 [1:8];
        logic         ch [1:8];
        logic         st [1:8];
        int           nch;
        rand_signal_a = 4'd5;
        #1 rst = 1'b0;
        @(posedge clk_a); #1;
        checks++; if (dut.src_q !== 4'd5) begin errors++; $display("FAIL basic_src_q got=%h exp=5", dut.src_q); end
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_b); #1;
            r2[i] = rand_b2; r3[i] = rand_b3; ch[i] = change_b2; st[i] = stable_b2;
        end
        lat_basic2 = 0; lat_basic3 = 0; nch = 0;
        for (int i = 8; i >= 1; i--) begin
            if (r2[i] === 4'd5) lat_basic2 = i;
            if (r3[i] === 4'd5) lat_basic3 = i;
        end
        for (int i = 1; i <= 8; i++) if (ch[i] === 1'b1) nch++;
        checks++; if (lat_basic2 < 1 || lat_basic2 > 3) begin errors++; $display("FAIL basic_latency got=%0d exp=1..3", lat_basic2); end
        checks++; if (dut.sync_ff1 !== 4'd5) begin errors++; $display("FAIL basic_sync_ff1 got=%h exp=5", dut.sync_ff1); end
        checks++; if (dut.sync_ff2 !== 4'd5) begin errors++; $display("FAIL basic_sync_ff2 got=%h exp=5", dut.sync_ff2); end
        checks++; if (rand_b2 !== 4'd5)      begin errors++; $display("FAIL basic_rand_b got=%h exp=5", rand_b2); end
        checks++; if (nch != 1)              begin errors++; $display("FAIL basic_change_count got=%0d exp=1", nch); end
        if (lat_basic2 >= 1 && lat_basic2 <= 7) begin
            checks++; if (ch[lat_basic2+1] !== 1'b1) begin errors++; $display("FAIL basic_change_pos got=%b exp=1", ch[lat_basic2+1]); end
            checks++; if (st[lat_basic2+1] !== 1'b1) begin errors++; $display("FAIL basic_stable got=%b exp=1", st[lat_basic2+1]); end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_step();
        int  lat, nch;
        bit  saw_low;
        @(negedge clk_a);
        rand_signal_a = 4'd8;
        @(posedge clk_a); #1;
        checks++; if (dut.src_q !== 4'd8) begin errors++; $display("FAIL step_src_q got=%h exp=8", dut.src_q); end
        lat = 0; nch = 0; saw_low = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk_b); #1;
            if (lat == 0 && rand_b2 === 4'd8) lat = i;
            if (change_b2 === 1'b1) nch++;
            if (stable_b2 === 1'b0) saw_low = 1'b1;
        end
        checks++; if (lat < 1 || lat > 3) begin errors++; $display("FAIL step_latency got=%0d exp=1..3", lat); end
        checks++; if (!saw_low)           begin errors++; $display("FAIL step_stable_drop got=%b exp=1", saw_low); end
        checks++; if (stable_b2 !== 1'b1) begin errors++; $display("FAIL step_stable_final got=%b exp=1", stable_b2); end
        checks++; if (rand_b2 !== 4'd8)   begin errors++; $display("FAIL step_final got=%h exp=8", rand_b2); end
        checks++; if (rand_b3 !== 4'd8)   begin errors++; $display("FAIL step_final3 got=%h exp=8", rand_b3); end
        checks++; if (nch != 1)           begin errors++; $display("FAIL step_change_count got=%0d exp=1", nch); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_reset();
        @(negedge clk_b);
        rst = 1'b1;
        #1;
        checks++; if (rand_b2 !== 4'd0)      begin errors++; $display("FAIL midrst_rand_b got=%h exp=0", rand_b2); end
        checks++; if (change_b2 !== 1'b0)    begin errors++; $display("FAIL midrst_change_b got=%b exp=0", change_b2); end
        checks++; if (stable_b2 !== 1'b0)    begin errors++; $display("FAIL midrst_stable_b got=%b exp=0", stable_b2); end
        checks++; if (dut.sync_ff1 !== 4'd0) begin errors++; $display("FAIL midrst_sync_ff1 got=%h exp=0", dut.sync_ff1); end
        checks++; if (dut.src_q !== 4'd0)    begin errors++; $display("FAIL midrst_src_q got=%h exp=0", dut.src_q); end
        checks++; if (rand_b3 !== 4'd0)      begin errors++; $display("FAIL midrst_rand_b3 got=%h exp=0", rand_b3); end
        #11 rst = 1'b0;
        lat_rst2 = 0; lat_rst3 = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk_b); #1;
            if (lat_rst2 == 0 && rand_b2 === 4'd8) lat_rst2 = i;
            if (lat_rst3 == 0 && rand_b3 === 4'd8) lat_rst3 = i;
            if (i <= 2) begin
                checks++; if (rand_b2 !== 4'd0) begin errors++; $display("FAIL midrst_hold edge=%0d got=%h exp=0", i, rand_b2); end
            end
            if (i <= 4) begin
                checks++; if (change_b2 !== 1'b0) begin errors++; $display("FAIL midrst_no_pulse edge=%0d got=%b exp=0", i, change_b2); end
            end
            if (i == 5) begin
                checks++; if (change_b2 !== 1'b1) begin errors++; $display("FAIL midrst_pulse got=%b exp=1", change_b2); end
            end
        end
        checks++; if (lat_rst2 != 4) begin errors++; $display("FAIL midrst_latency got=%0d exp=4", lat_rst2); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        fork
            begin
                repeat (50) begin
                    @(negedge clk_a);
                    rand_signal_a = W'($urandom_range(8, 2));
                end
            end
            begin
                logic [W-1:0] r_m1, r_m2, ff1_m1;
                for (int k = 0; k < 36; k++) begin
                    @(negedge clk_b);
                    checks++;
                    if (!(rand_b2 === 4'd0 || (rand_b2 >= 4'd2 && rand_b2 <= 4'd8))) begin
                        errors++; $display("FAIL rand_range k=%0d got=%h exp=0|2..8", k, rand_b2);
                    end
                    if (k >= 1) begin
                        checks++; if (dut.prev_b !== r_m1) begin errors++; $display("FAIL rand_prev_b k=%0d got=%h exp=%h", k, dut.prev_b, r_m1); end
                        checks++; if (stable_b2 !== (r_m1 == ff1_m1)) begin errors++; $display("FAIL rand_stable k=%0d got=%b exp=%b", k, stable_b2, (r_m1 == ff1_m1)); end
                    end
                    if (k >= 2) begin
                        checks++; if (change_b2 !== (r_m1 != r_m2)) begin errors++; $display("FAIL rand_change k=%0d got=%b exp=%b", k, change_b2, (r_m1 != r_m2)); end
                    end
                    r_m2 = r_m1; r_m1 = rand_b2; ff1_m1 = dut.sync_ff1;
                end
            end
        join
    endtask

    // ------------------------------------------------------------------
    task automatic test_depth();
        checks++; if (lat_basic3 != lat_basic2 + 1) begin errors++; $display("FAIL depth_basic got=%0d exp=%0d", lat_basic3, lat_basic2 + 1); end
        checks++; if (lat_rst3 != lat_rst2 + 1)     begin errors++; $display("FAIL depth_midrst got=%0d exp=%0d", lat_rst3, lat_rst2 + 1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_step();
        test_mid_reset();
        test_random();
        test_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
